ascon_sbox_bank: RTL

Multi-lane programmable 5-bit S-box for the Ascon permutation datapath, replacing the single-read programmable S-box. It holds a row-organised lookup table, reloadable at run time through a valid/ready configuration port, and serves `LANES` independent lookups per cycle through a registered valid/ready stream stage. It sits between the round-constant adder and the linear diffusion layer. An optional shadow bank allows the table to be reprogrammed while lookups continue against the committed table.

---
 rtl/ascon_sbox_pkg.sv | 19 +
 rtl/ascon_sbox_lane.sv | 18 +
 rtl/ascon_sbox_bank.sv | 94 +++++++++
 3 files changed

// File: rtl/ascon_sbox_pkg.sv
// ascon_sbox_pkg: Ascon 5-bit S-box constant, default-table helper and index types.
package ascon_sbox_pkg;
  localparam logic [4:0] ASCON_SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 4;
  typedef logic [$clog2(DEF_ROWS)-1:0] row_idx_t;
  typedef logic [$clog2(DEF_COLS)-1:0] col_idx_t;
  // Ascon table only for the native 5-in/5-out shape; identity otherwise.
  function automatic logic [31:0] default_entry(input int i, input int in_w, input int out_w);
    logic [31:0] v;
    v = (in_w == 5 && out_w == 5) ? {27'd0, ASCON_SBOX[i[4:0]]} : i;
    return v;
  endfunction
endpackage

// File: rtl/ascon_sbox_lane.sv
// ascon_sbox_lane: combinational row/column select of one table entry.
module ascon_sbox_lane
  import ascon_sbox_pkg::*;
#(
  parameter int IN_W = 5,
  parameter int OUT_W = 5,
  parameter int ENTRIES_PER_ROW = 4
) (
  input  logic [(2**IN_W)*OUT_W-1:0] tbl_i,
  input  logic [IN_W-1:0]            idx_i,
  output logic [OUT_W-1:0]           data_o
);
  localparam int COL_W = $clog2(ENTRIES_PER_ROW);
  localparam int RW = ENTRIES_PER_ROW * OUT_W;
  logic [RW-1:0] row;
  assign row = tbl_i[idx_i[IN_W-1:COL_W]*RW +: RW];
  assign data_o = row[idx_i[COL_W-1:0]*OUT_W +: OUT_W];
endmodule

// File: rtl/ascon_sbox_bank.sv
// ascon_sbox_bank: multi-lane reloadable S-box with registered valid/ready output.
// ASCON_SBOX_SHADOW_EN adds a shadow bank published by cfg_commit_i.
module ascon_sbox_bank
  import ascon_sbox_pkg::*;
#(
  parameter int IN_W = 5,
  parameter int OUT_W = 5,
  parameter int ENTRIES_PER_ROW = 4,
  parameter int LANES = 4,
  localparam int ROWS = (2**IN_W) / ENTRIES_PER_ROW,
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  input  logic [ROW_W-1:0]             cfg_row_i,
  input  logic [ENTRIES_PER_ROW*OUT_W-1:0] cfg_data_i,
  input  logic                         cfg_commit_i,
  output logic [3:0]                   table_gen_o,
  input  logic                         lk_valid_i,
  output logic                         lk_ready_o,
  input  logic [LANES*IN_W-1:0]        lk_data_i,
  output logic                         lk_valid_o,
  input  logic                         lk_ready_i,
  output logic [LANES*OUT_W-1:0]       lk_data_o
);
  localparam int RW = ENTRIES_PER_ROW * OUT_W;
  function automatic logic [RW-1:0] def_row(input int r);
    logic [RW-1:0] v;
    for (int c = 0; c < ENTRIES_PER_ROW; c++)
      v[c*OUT_W +: OUT_W] = OUT_W'(default_entry(r*ENTRIES_PER_ROW + c, IN_W, OUT_W));
    return v;
  endfunction
  logic [RW-1:0] act_q [ROWS];
  logic [RW-1:0] act_d [ROWS];
  logic cfg_ready_q, cfg_ready_d, lk_valid_q, lk_valid_d;
  logic [3:0] gen_q, gen_d;
  logic [LANES*OUT_W-1:0] lk_data_q, lk_data_d, lane_res;
  logic [ROWS*RW-1:0] tbl;
  logic wr, acc;
  assign wr = cfg_valid_i && cfg_ready_q;
  assign lk_ready_o = !lk_valid_q || lk_ready_i;
  assign acc = lk_valid_i && lk_ready_o;
  assign cfg_ready_o = cfg_ready_q;
  assign table_gen_o = gen_q;
  assign lk_valid_o = lk_valid_q;
  assign lk_data_o = lk_data_q;
`ifdef ASCON_SBOX_SHADOW_EN
  logic [RW-1:0] sh_q [ROWS];
  logic [RW-1:0] sh_d [ROWS];
  always_comb begin
    sh_d = sh_q;
    if (wr) sh_d[cfg_row_i] = cfg_data_i;
    act_d = cfg_commit_i ? sh_d : act_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < ROWS; r++) sh_q[r] <= def_row(r);
    else sh_q <= sh_d;
`else
  always_comb begin
    act_d = act_q;
    if (wr) act_d[cfg_row_i] = cfg_data_i;
  end
`endif
  always_comb begin
    tbl = '0;
    for (int r = 0; r < ROWS; r++) tbl[r*RW +: RW] = act_q[r];
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ascon_sbox_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .ENTRIES_PER_ROW(ENTRIES_PER_ROW)) u_lane (
      .tbl_i(tbl), .idx_i(lk_data_i[k*IN_W +: IN_W]), .data_o(lane_res[k*OUT_W +: OUT_W]));
  end
  always_comb begin
    cfg_ready_d = 1'b1;
    gen_d = gen_q + {3'd0, cfg_commit_i};
    lk_valid_d = acc ? 1'b1 : (lk_ready_i ? 1'b0 : lk_valid_q);
    lk_data_d = acc ? lane_res : lk_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) act_q[r] <= def_row(r);
      cfg_ready_q <= 1'b0;
      gen_q <= '0;
      lk_valid_q <= 1'b0;
      lk_data_q <= '0;
    end else begin
      act_q <= act_d;
      cfg_ready_q <= cfg_ready_d;
      gen_q <= gen_d;
      lk_valid_q <= lk_valid_d;
      lk_data_q <= lk_data_d;
    end
endmodule
